// File: rtl/alu_seq_exec.sv
// alu_seq_exec
//   Execute-stage ALU. Single-cycle ops (ADD/SUB/OR/AND/SLT/SLL) and iterative
//   MULT (shift-add) / DIV (restoring), one bit per cycle, behind a
//   start/busy/done handshake. Operands and op code are captured on start.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             latch IA/A/B and begin (ignored while busy)
//   IA                op code (ADD,SUB,MULT,DIV,OR,AND,SLT,SLL/NOP)
//   A, B              operands; SLL shift amount is A[$clog2(WIDTH)-1:0]
//   busy              high from the cycle after start until done
//   done              one-cycle pulse, outputs valid from this cycle on
//   result, hi        low word/quotient, high word/remainder
//   zero              registered result == 0
//   div_by_zero       DIV issued with B == 0
module alu_seq_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       IA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SINGLE, S_MUL, S_DIV, S_FIN
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MULT = 3'b010,
        OP_DIV  = 3'b011,
        OP_OR   = 3'b100,
        OP_AND  = 3'b101,
        OP_SLT  = 3'b110,
        OP_SLL  = 3'b111
    } op_t;

    state_t             state_q;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    // Shared work register: {hi, lo} for MULT, {remainder, quotient} for DIV,
    // {hi, result} staged by SINGLE.
    logic [2*WIDTH-1:0] work_q;
    logic [CW-1:0]      cnt_q;
    logic               dbz_pend_q;
    logic               done_q, zero_q, dbz_q;
    logic [WIDTH-1:0]   result_q, hi_q;

    // Single-cycle results
    logic [WIDTH-1:0]   single_lo_d, single_hi_d;
    logic               single_dbz_d;
    logic               slt_bit;

    always_comb begin
        single_lo_d  = '0;
        single_hi_d  = '0;
        single_dbz_d = 1'b0;
        slt_bit      = $signed(a_q) < $signed(b_q);
        case (op_q)
            OP_ADD: single_lo_d = a_q + b_q;
            OP_SUB: single_lo_d = a_q - b_q;
            OP_OR:  single_lo_d = a_q | b_q;
            OP_AND: single_lo_d = a_q & b_q;
            OP_SLT: single_lo_d = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLL: single_lo_d = b_q << a_q[SHW-1:0];
            OP_DIV: begin
                // Only reaches SINGLE when B == 0
                single_lo_d  = '1;
                single_hi_d  = a_q;
                single_dbz_d = 1'b1;
            end
            default: single_lo_d = '0;
        endcase
    end

    // Shift-add multiply step: add multiplicand into upper half when LSB set,
    // then shift the whole {carry, upper, lower} right by one.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // Restoring divide step: shift {rem, quot} left, trial-subtract divisor.
    logic [WIDTH:0]     div_sh, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                 + ({(WIDTH+1){work_q[0]}} & {1'b0, a_q});
        mul_next = {mul_sum, work_q[WIDTH-1:1]};

        div_sh   = work_q[2*WIDTH-1:WIDTH-1];
        div_ge   = div_sh >= {1'b0, b_q};
        div_sub  = div_sh - {1'b0, b_q};
        div_next = div_ge ? {div_sub[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1}
                          : {div_sh[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            dbz_pend_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            hi_q       <= '0;
            zero_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q       <= op_t'(IA);
                        a_q        <= A;
                        b_q        <= B;
                        cnt_q      <= '0;
                        dbz_pend_q <= 1'b0;
                        if (IA == OP_MULT) begin
                            work_q  <= {{WIDTH{1'b0}}, B};
                            state_q <= S_MUL;
                        end else if (IA == OP_DIV && B != '0) begin
                            work_q  <= {{WIDTH{1'b0}}, A};
                            state_q <= S_DIV;
                        end else begin
                            state_q <= S_SINGLE;
                        end
                    end
                end
                S_SINGLE: begin
                    work_q     <= {single_hi_d, single_lo_d};
                    dbz_pend_q <= single_dbz_d;
                    state_q    <= S_FIN;
                end
                // WIDTH iterations at cnt 0..WIDTH-1; the cnt==WIDTH cycle only
                // hands over to FIN, so done lands WIDTH+2 edges after start.
                S_MUL: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        state_q <= S_FIN;
                    end else begin
                        work_q <= mul_next;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_DIV: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        state_q <= S_FIN;
                    end else begin
                        work_q <= div_next;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    result_q <= work_q[WIDTH-1:0];
                    hi_q     <= work_q[2*WIDTH-1:WIDTH];
                    zero_q   <= (work_q[WIDTH-1:0] == '0);
                    dbz_q    <= dbz_pend_q;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule
